spi_fifo_bridge: RTL

//  Command/data bridge between the byte-level SPI slave and NUM_CH sample FIFOs.

---
 rtl/spi_fifo_bridge.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_fifo_bridge.sv
// Opcode decoder and burst streamer between a byte-level SPI slave and NUM_CH sample FIFOs.
// A FIFO byte reaches tx_data 2 edges after its read strobe; tx_done paces the burst, and low spi_active aborts it.
module spi_fifo_bridge #(
    parameter int          NUM_CH    = 2,
    parameter int          LVL_W     = 7,
    parameter logic [7:0]  CTRL_RST  = 8'h00,
    parameter logic [7:0]  FILL_BYTE = 8'h00
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      spi_active_i,
    input  logic                      rx_valid_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      tx_done_i,
    output logic [7:0]                tx_data_o,
    output logic [NUM_CH-1:0]         fifo_rd_o,
    input  logic [8*NUM_CH-1:0]       fifo_dat_i,
    input  logic [NUM_CH-1:0]         fifo_empty_i,
    input  logic [LVL_W*NUM_CH-1:0]   fifo_level_i,
    output logic [7:0]                ctrl_reg_o,
    output logic                      sd_en_o,
    output logic                      busy_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CTRL,
        S_GET_LEN,
        S_FETCH,
        S_CAPT,
        S_STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          tx_q, tx_d;
    logic [7:0]          ctrl_q, ctrl_d;
    logic [NUM_CH-1:0]   rd_q, rd_d;
    logic [NUM_CH-1:0]   undr_q, undr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [7:0]          sel_dat;
    logic [LVL_W-1:0]    op_lvl;
    logic                op_ch_ok;
    logic                start_fetch;

    always_comb begin
        sel_dat  = '0;
        op_lvl   = '0;
        op_ch_ok = (rx_data_i[3:0] < 4'(NUM_CH));
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i))
                sel_dat = fifo_dat_i[8*i +: 8];
            if (rx_data_i[3:0] == 4'(i))
                op_lvl = fifo_level_i[LVL_W*i +: LVL_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        ctrl_d      = ctrl_q;
        rd_d        = '0;
        undr_d      = undr_q;
        ch_d        = ch_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        start_fetch = 1'b0;

        if (!spi_active_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == 8'h02) begin
                            state_d = S_WR_CTRL;
                        end else if (rx_data_i == 8'h03) begin
                            tx_d = ctrl_q;
                        end else if (rx_data_i == 8'h04) begin
                            tx_d   = 8'(undr_q);
                            undr_d = '0;
                        end else if (rx_data_i[7:4] == 4'h1 && op_ch_ok) begin
                            tx_d = 8'(op_lvl);
                        end else if (rx_data_i[7:4] == 4'hC && op_ch_ok) begin
                            ch_d    = CH_W'(rx_data_i[3:0]);
                            state_d = S_GET_LEN;
                        end
                    end
                end
                S_WR_CTRL: begin
                    if (rx_valid_i) begin
                        ctrl_d  = rx_data_i;
                        state_d = S_IDLE;
                    end
                end
                S_GET_LEN: begin
                    if (rx_valid_i) begin
                        len_d = rx_data_i;
                        cnt_d = '0;
                        if (rx_data_i == 8'h00) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d     = S_FETCH;
                            start_fetch = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    // The strobe was issued on entry, so a raised rd_q means data is on its way.
                    if (|rd_q) begin
                        state_d = S_CAPT;
                    end else begin
                        tx_d = FILL_BYTE;
                        for (int i = 0; i < NUM_CH; i++)
                            if (ch_q == CH_W'(i))
                                undr_d[i] = 1'b1;
                        state_d = S_STREAM;
                    end
                end
                S_CAPT: begin
                    tx_d    = sel_dat;
                    state_d = S_STREAM;
                end
                S_STREAM: begin
                    if (tx_done_i) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == len_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d     = S_FETCH;
                            start_fetch = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (start_fetch)
                for (int i = 0; i < NUM_CH; i++)
                    if (ch_q == CH_W'(i) && !fifo_empty_i[i])
                        rd_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            tx_q    <= '0;
            ctrl_q  <= CTRL_RST;
            rd_q    <= '0;
            undr_q  <= '0;
            ch_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            undr_q  <= undr_d;
            ch_q    <= ch_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_data_o  = tx_q;
    assign fifo_rd_o  = rd_q;
    assign ctrl_reg_o = ctrl_q;
    assign sd_en_o    = ctrl_q[0];
    assign busy_o     = (state_q != S_IDLE);

endmodule
